register_file: RTL and testbench
================================

# register_file

Parametrised multi-entry register bank replacing the single 8-bit enable register in the datapath. Holds DEPTH words of WIDTH bits. Provides one synchronous write port with an in-place arithmetic operation (load, increment, decrement, clear) and two independent combinational read ports. Registered carry/zero flags report the result of the most recent write. Sits between the ALU/bus and the control unit as the general-purpose register set.

## Interface
Parameters:
- WIDTH, 8, bits per register
- DEPTH, 4, number of registers (≥2)
- ADDR_W, 2, address width; DEPTH ≤ 2^ADDR_W

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  write enable; a write occurs only when enable === 1 (X/Z = no write)
- op  in  2  write operation: 00 load, 01 increment, 10 decrement, 11 clear
- waddr  in  ADDR_W  write address
- data  in  WIDTH  load value (used only for op=00)
- raddr_a  in  ADDR_W  read address, port A
- raddr_b  in  ADDR_W  read address, port B
- out_a  out  WIDTH  contents of reg[raddr_a]
- out_b  out  WIDTH  contents of reg[raddr_b]
- carry  out  1  carry/borrow of last write
- zero  out  1  last write result == 0

## Operation
- Next value for reg[waddr]: load → data; inc → reg+1 mod 2^WIDTH; dec → reg−1 mod 2^WIDTH; clear → 0.
- carry: inc from all-ones (wrap to 0) → 1; dec from 0 (wrap to all-ones) → 1; otherwise 0; load/clear → 0.
- zero: 1 iff written result == 0.
- Flags update only on a performed write; otherwise they hold.
- waddr ≥ DEPTH: write ignored; registers and flags unchanged.
- raddr ≥ DEPTH: corresponding output reads 0.
- Read ports are independent; raddr_a == raddr_b is legal and both return the same value.
- Only reg[waddr] changes on a write; all other entries hold.

## Timing
- Reset (reset_n=0, asynchronous, no clock needed): all registers 0, carry=0, zero=0; out_a/out_b read 0 immediately.
- Reset asserted mid-operation overrides any pending write; the edge coinciding with reset_n=0 performs no write.
- First rising edge with reset_n=1 operates normally.
- Write latency: one clock. The result is stored and the flags are updated on the rising edge where enable===1.
- Read latency: combinational from raddr and stored contents. The new value is visible on out_x after the write edge (see Configuration for same-cycle bypass).
- Back-to-back writes to the same address chain correctly. Example: inc, inc on consecutive edges from 5 gives 6, then 7.

## Configuration
- Macro REGISTER_FILE_BYPASS_EN.
- Defined: when enable===1, waddr < DEPTH and raddr_x == waddr, out_x combinationally shows the computed next value in the same cycle, before the edge. Flags are not bypassed.
- Undefined: out_x always shows the stored value; a written value becomes visible only after the edge.

## Test plan
- Reset: pulse reset_n low between edges → all outputs 0 immediately; carry=0, zero=0; reads of every address return 0.
- Load and read: load 0xA5→r1, then 0x3C→r2 → out_a(r1)=0xA5, out_b(r2)=0x3C, zero=0, carry=0; r0 and r3 remain 0.
- Wrap: load 0xFF→r0, inc → r0=0x00, carry=1, zero=1; dec → r0=0xFF, carry=1, zero=0; dec → 0xFE, carry=0.
- Guards: enable=0 or enable=X with op=load 0x11 → no register or flag change; waddr ≥ DEPTH (DEPTH=3 build) → ignored; raddr ≥ DEPTH → 0.
- Async reset mid-op: assert reset_n low 1 ns before an edge carrying a load of 0x77 → r stays 0 and flags are reset; release → next load of 0x77 succeeds.
- Bypass: r2=0x10, enable=1, op=inc, waddr=raddr_a=2 before the edge → out_a=0x11 with REGISTER_FILE_BYPASS_EN defined, 0x10 without it; both builds show 0x11 after the edge.

Source files
------------

// File: rtl/register_file.sv
// register_file: general-purpose register bank with one write port that can
// load, increment, decrement or clear an entry in place, plus two independent
// combinational read ports. Registered carry/zero flags describe the most
// recent performed write.
//
// Optional feature macro: REGISTER_FILE_BYPASS_EN
//   defined   - a read port addressing the entry being written this cycle shows
//               the value that will be stored at the coming edge (flags are not
//               bypassed)
//   undefined - read ports always show the stored contents
module register_file #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  data,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  out_a,
   output logic [WIDTH-1:0]  out_b,
   output logic              carry,
   output logic              zero
);

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_INC   = 2'b01,
      OP_DEC   = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   // One extra bit so that DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] regs_q   [DEPTH];
   logic [WIDTH-1:0] regs_d   [DEPTH];
   logic [WIDTH-1:0] rd_src_s [DEPTH];
   logic             carry_q;
   logic             carry_d;
   logic             zero_q;
   logic             zero_d;
   logic             wr_valid_s;
   logic [WIDTH-1:0] cur_s;
   logic [WIDTH-1:0] next_s;
   logic             next_carry_s;

   // Qualify the write: only a definite enable, out of reset, to an existing entry.
   always_comb begin
      wr_valid_s = 1'b0;
      if ((enable == 1'b1) && (reset_n == 1'b1) && ({1'b0, waddr} < DEPTH_C)) begin
         wr_valid_s = 1'b1;
      end else begin
         wr_valid_s = 1'b0;
      end
   end

   // Select the current contents of the entry addressed by the write port.
   always_comb begin
      cur_s = {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         cur_s = cur_s | (regs_q[i] & {WIDTH{waddr == ADDR_W'(i)}});
      end
   end

   // Compute the written result and its carry/borrow for the requested operation.
   always_comb begin
      next_s       = {WIDTH{1'b0}};
      next_carry_s = 1'b0;
      case (op_e'(op))
         OP_LOAD: begin
            next_s       = data;
            next_carry_s = 1'b0;
         end
         OP_INC: begin
            // Carry out of the extended sum marks the all-ones -> 0 wrap.
            {next_carry_s, next_s} = {1'b0, cur_s} + {{WIDTH{1'b0}}, 1'b1};
         end
         OP_DEC: begin
            // Borrow appears as the top bit when decrementing from 0.
            {next_carry_s, next_s} = {1'b0, cur_s} - {{WIDTH{1'b0}}, 1'b1};
         end
         OP_CLEAR: begin
            next_s       = {WIDTH{1'b0}};
            next_carry_s = 1'b0;
         end
         default: begin
            next_s       = {WIDTH{1'b0}};
            next_carry_s = 1'b0;
         end
      endcase
   end

   // Next state of the bank: only the addressed entry takes the new value.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_valid_s && (waddr == ADDR_W'(i))) begin
            regs_d[i] = next_s;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Flags follow a performed write and hold otherwise.
   always_comb begin
      carry_d = carry_q;
      zero_d  = zero_q;
      if (wr_valid_s) begin
         carry_d = next_carry_s;
         zero_d  = (next_s == {WIDTH{1'b0}});
      end else begin
         carry_d = carry_q;
         zero_d  = zero_q;
      end
   end

   // Register bank and flags; asynchronous reset clears everything.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= {WIDTH{1'b0}};
         end
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

`ifdef REGISTER_FILE_BYPASS_EN
   // Reads see the pending write value for the entry being written this cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rd_src_s[i] = regs_d[i];
      end
   end
`else
   // Reads see only the stored contents.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rd_src_s[i] = regs_q[i];
      end
   end
`endif

   // Read port A; addresses beyond the bank match no entry and read 0.
   always_comb begin
      out_a = {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         out_a = out_a | (rd_src_s[i] & {WIDTH{raddr_a == ADDR_W'(i)}});
      end
   end

   // Read port B; addresses beyond the bank match no entry and read 0.
   always_comb begin
      out_b = {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         out_b = out_b | (rd_src_s[i] & {WIDTH{raddr_b == ADDR_W'(i)}});
      end
   end

   // Flags are driven straight from their flops.
   always_comb begin
      carry = carry_q;
      zero  = zero_q;
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a full-depth instance (DEPTH=4) and a
// short instance (DEPTH=3) share all inputs so out-of-range addressing can be
// checked alongside the normal bank.
module tb_register_file;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic [1:0] op;
   logic [1:0] waddr;
   logic [7:0] data;
   logic [1:0] raddr_a;
   logic [1:0] raddr_b;
   logic [7:0] out_a0, out_b0, out_a1, out_b1;
   logic       carry0, zero0, carry1, zero1;

   int tests;
   int fails;

   register_file #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u0 (
      .clock(clock), .reset_n(reset_n), .enable(enable), .op(op),
      .waddr(waddr), .data(data), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .out_a(out_a0), .out_b(out_b0), .carry(carry0), .zero(zero0)
   );

   register_file #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u1 (
      .clock(clock), .reset_n(reset_n), .enable(enable), .op(op),
      .waddr(waddr), .data(data), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .out_a(out_a1), .out_b(out_b1), .carry(carry1), .zero(zero1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // One write on the next rising edge, then drop enable just after it.
   task automatic wr(input logic [1:0] o, input logic [1:0] a, input logic [7:0] d);
      enable = 1'b1;
      op     = o;
      waddr  = a;
      data   = d;
      @(posedge clock);
      #1;
      enable = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [1:0] b);
      raddr_a = a;
      raddr_b = b;
      #1;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      reset_n = 1'b0;
      enable  = 1'b0;
      op      = 2'b00;
      waddr   = 2'd0;
      data    = 8'h00;
      raddr_a = 2'd0;
      raddr_b = 2'd0;

      // Reset state
      #2;
      check("rst_carry", {7'd0, carry0}, 8'h00);
      check("rst_zero",  {7'd0, zero0},  8'h00);
      for (int i = 0; i < 4; i++) begin
         rd(2'(i), 2'(3 - i));
         check("rst_out_a", out_a0, 8'h00);
         check("rst_out_b", out_b0, 8'h00);
      end
      @(negedge clock);
      reset_n = 1'b1;

      // Load and read
      wr(2'b00, 2'd1, 8'hA5);
      check("ld1_zero",  {7'd0, zero0},  8'h00);
      check("ld1_carry", {7'd0, carry0}, 8'h00);
      wr(2'b00, 2'd2, 8'h3C);
      rd(2'd1, 2'd2);
      check("ld_out_a_r1", out_a0, 8'hA5);
      check("ld_out_b_r2", out_b0, 8'h3C);
      check("ld_u1_r1",    out_a1, 8'hA5);
      rd(2'd0, 2'd3);
      check("ld_r0_zero", out_a0, 8'h00);
      check("ld_r3_zero", out_b0, 8'h00);

      // Wrap behaviour on r0
      wr(2'b00, 2'd0, 8'hFF);
      wr(2'b01, 2'd0, 8'h00);
      rd(2'd0, 2'd0);
      check("inc_wrap_val",   out_a0, 8'h00);
      check("inc_wrap_carry", {7'd0, carry0}, 8'h01);
      check("inc_wrap_zero",  {7'd0, zero0},  8'h01);
      check("inc_wrap_u1_c",  {7'd0, carry1}, 8'h01);
      wr(2'b10, 2'd0, 8'h00);
      check("dec_wrap_val",   out_a0, 8'hFF);
      check("dec_wrap_carry", {7'd0, carry0}, 8'h01);
      check("dec_wrap_zero",  {7'd0, zero0},  8'h00);
      wr(2'b10, 2'd0, 8'h00);
      check("dec_val",   out_a0, 8'hFE);
      check("dec_carry", {7'd0, carry0}, 8'h00);

      // Back-to-back increments on r3 (absent in the DEPTH=3 instance)
      wr(2'b00, 2'd3, 8'h05);
      wr(2'b01, 2'd3, 8'h00);
      wr(2'b01, 2'd3, 8'h00);
      rd(2'd3, 2'd3);
      check("b2b_out_a", out_a0, 8'h07);
      check("b2b_out_b", out_b0, 8'h07);
      check("u1_raddr_oob", out_a1, 8'h00);

      // Clear sets zero
      wr(2'b11, 2'd1, 8'h00);
      rd(2'd1, 2'd2);
      check("clr_val",  out_a0, 8'h00);
      check("clr_zero", {7'd0, zero0}, 8'h01);

      // enable=0: no register or flag change
      enable = 1'b0;
      op     = 2'b00;
      waddr  = 2'd1;
      data   = 8'h11;
      @(posedge clock);
      #1;
      rd(2'd1, 2'd2);
      check("noen_r1",   out_a0, 8'h00);
      check("noen_r2",   out_b0, 8'h3C);
      check("noen_zero", {7'd0, zero0}, 8'h01);

      // waddr beyond the short bank: u0 writes, u1 ignores
      wr(2'b00, 2'd3, 8'h11);
      rd(2'd3, 2'd0);
      check("oob_u0_r3",   out_a0, 8'h11);
      check("oob_u0_zero", {7'd0, zero0}, 8'h00);
      check("oob_u1_r3",   out_a1, 8'h00);
      check("oob_u1_zero", {7'd0, zero1}, 8'h01);
      check("oob_u1_r0",   out_b1, 8'hFE);

      // Reset pulse between edges clears outputs immediately
      reset_n = 1'b0;
      #1;
      check("rpulse_out_a", out_a0, 8'h00);
      check("rpulse_out_b", out_b0, 8'h00);
      check("rpulse_zero",  {7'd0, zero0}, 8'h00);
      check("rpulse_u1_z",  {7'd0, zero1}, 8'h00);
      reset_n = 1'b1;
      #1;

      // Async reset just before an edge carrying a load
      wr(2'b10, 2'd0, 8'h00);
      check("pre_carry", {7'd0, carry0}, 8'h01);
      enable  = 1'b1;
      op      = 2'b00;
      waddr   = 2'd2;
      data    = 8'h77;
      raddr_a = 2'd2;
      raddr_b = 2'd0;
      #8;
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check("mid_r2",    out_a0, 8'h00);
      check("mid_r0",    out_b0, 8'h00);
      check("mid_carry", {7'd0, carry0}, 8'h00);
      check("mid_zero",  {7'd0, zero0},  8'h00);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      enable = 1'b0;
      check("post_rst_load", out_a0, 8'h77);

      // Same-cycle visibility of a pending write
      wr(2'b00, 2'd2, 8'h10);
      enable  = 1'b1;
      op      = 2'b01;
      waddr   = 2'd2;
      raddr_a = 2'd2;
      #1;
`ifdef REGISTER_FILE_BYPASS_EN
      check("bypass_pre", out_a0, 8'h11);
`else
      check("bypass_pre", out_a0, 8'h10);
`endif
      @(posedge clock);
      #1;
      enable = 1'b0;
      check("bypass_post",  out_a0, 8'h11);
      check("bypass_carry", {7'd0, carry0}, 8'h00);
      check("bypass_zero",  {7'd0, zero0},  8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
